dw_tap_sequencer: RTL and testbench
===================================

# dw_tap_sequencer

Front-end sequencer for the depthwise SIMD datapath. It holds one K×K kernel per lane and streams window taps into a row of `LANES` accumulating PEs, driving each PE's `k`, `in` and `first_data` inputs. Once a window's last product has been absorbed, it captures every PE `sum` and returns the vector through a valid/ready result port. It is the driver side of the PE's `k`/`in`/`first_data` interface and the collector of its `sum` output.

## Interface
- `DATA_WIDTH`, 8: signed weight/activation width.
- `OUT_DATA_WIDTH`, 32: PE accumulator width.
- `LANES`, 4: number of PEs (channels) driven in parallel.
- `TAPS`, 9: taps per window (K×K).
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high; shared with the PE row.
- `w_wr_en`  in  1  weight write strobe.
- `w_wr_addr`  in  $clog2(TAPS)  tap index.
- `w_wr_data`  in  LANES*DATA_WIDTH  one weight per lane; lane i is at `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `start`  in  1  job start pulse.
- `num_pixels`  in  16  windows in the job; sampled on `start`.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse at job end.
- `act_valid`  in  1  activation tap valid.
- `act_ready`  out  1  tap accept.
- `act_data`  in  LANES*DATA_WIDTH  one tap per lane.
- `pe_k`  out  LANES*DATA_WIDTH  to PE `k`; registered.
- `pe_in`  out  LANES*DATA_WIDTH  to PE `in`; registered.
- `pe_first`  out  1  to all PE `first_data`; registered.
- `pe_sum`  in  LANES*OUT_DATA_WIDTH  from PE `sum`.
- `res_valid`  out  1  result valid.
- `res_ready`  in  1  result accept.
- `res_data`  out  LANES*OUT_DATA_WIDTH  captured sums.

## Operation
- **Weight RAM**
  - `TAPS` entries × `LANES*DATA_WIDTH`.
  - A write happens only in IDLE with `w_wr_addr < TAPS`; all other writes are dropped.
  - Reset clears every entry to 0.
- **FSM states:** IDLE, STREAM, DRAIN, CAPTURE, OUTPUT.
- **IDLE**
  - `start` with `num_pixels == 0`: `done` pulses on the next cycle; the FSM stays in IDLE.
  - `start` with `num_pixels > 0`: latch the count, clear `pix_cnt`, go to STREAM.
  - `start` is ignored in every other state.
- **STREAM**
  - `act_ready = 1`.
  - On a handshake: `pe_k <= W[tap_cnt]`, `pe_in <= act_data`, `pe_first <= (tap_cnt == 0)`, and `tap_cnt` increments.
  - With no handshake: `pe_k`, `pe_in` and `pe_first` are all driven to 0. The PEs accumulate every cycle with no enable, so a zero product holds the partial sum.
  - Accepting tap `TAPS-1` moves to DRAIN and resets `tap_cnt` to 0.
- **DRAIN:** zeros are driven to the PEs while the PEs absorb the last product; go to CAPTURE.
- **CAPTURE**
  - `pe_sum` is final in this cycle.
  - `res_data <= pe_sum`, `res_valid <= 1`; go to OUTPUT.
- **OUTPUT**
  - `res_data` is held stable.
  - When `res_valid && res_ready`: `res_valid` drops and `pix_cnt` increments.
  - If that was the last pixel, go to IDLE and pulse `done` on the same edge. Otherwise return to STREAM.
- `act_ready` is 0 in every state except STREAM.
- `pe_*` outputs are 0 in every state except the cycle after an accepted tap.
- **Arithmetic:** done entirely in the PE (signed multiply, `OUT_DATA_WIDTH`-bit two's-complement wrap). This block does no arithmetic except on its counters.

## Timing
- **Reset values:**
  - FSM in IDLE; `busy`, `done`, `act_ready`, `res_valid` = 0.
  - `pe_k`, `pe_in`, `pe_first`, `res_data` = 0.
  - `tap_cnt` and `pix_cnt` = 0.
- **Tap latency:** a tap accepted at edge N appears on `pe_*` after N; the PE registers its product at N+1.
- **Result latency:** last tap accepted at edge N → DRAIN during (N, N+1] → CAPTURE during (N+1, N+2] → `res_valid` high after N+2.
- **Throughput:** minimum `TAPS + 3` cycles per window when `act_valid` and `res_ready` are held high (12 cycles for TAPS = 9).
- **Reset mid-job:** the FSM aborts to IDLE and weights are cleared. The PEs clear because they share `reset`. The next job's first tap asserts `pe_first`, so no stale sum survives.
- **Start latency:** `busy` rises on the edge that samples `start` (when `num_pixels > 0`).
- **End of job:** `done` and the `busy` fall occur on the same edge as the final result handshake.

## Test plan
- **Basic window:** load `W = 1` for all taps and lanes; stream taps 1..9 in every lane, `num_pixels = 1` → `res_data` lanes = 45 each; `res_valid` appears 2 cycles after the 9th accept; `done` pulses with the result handshake.
- **Signed extremes:** `W = -128`, act = -128 on all taps → each lane = 147456. Lane-distinct weights 1, 2, 3, 4 with act = 1 → lanes 9, 18, 27, 36.
- **Input bubbles:** `act_valid` toggles every cycle in test 1 → still 45; `pe_k`, `pe_in` and `pe_first` are 0 in the bubble cycles.
- **Result backpressure:** `num_pixels = 3`, `res_ready` held low for 5 cycles per result → `res_data` stable and `act_ready` = 0 while stalled; three correct results, then exactly one `done`.
- **Reset mid-stream:** assert `reset` after 4 taps, then load `W = 1` and rerun test 1 → 45; `busy` = 0 and `res_valid` = 0 right after reset.
- **Edge cases:**
  - `num_pixels = 0` → `done` one cycle after `start`, `busy` never rises.
  - A `w_wr_en` during STREAM is ignored: the weight is unchanged on the next job.
  - `w_wr_addr = 9` is ignored.

Source files
------------

// File: rtl/dw_tap_sequencer.sv
// Tap sequencer for the depthwise PE row: holds one K*K kernel per lane, streams
// weight/activation taps into the accumulating PEs and returns each window's sums.
module dw_tap_sequencer #(
    parameter int DATA_WIDTH     = 8,
    parameter int OUT_DATA_WIDTH = 32,
    parameter int LANES          = 4,
    parameter int TAPS           = 9
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            w_wr_en,
    input  logic [$clog2(TAPS)-1:0]         w_wr_addr,
    input  logic [LANES*DATA_WIDTH-1:0]     w_wr_data,
    input  logic                            start,
    input  logic [15:0]                     num_pixels,
    output logic                            busy,
    output logic                            done,
    input  logic                            act_valid,
    output logic                            act_ready,
    input  logic [LANES*DATA_WIDTH-1:0]     act_data,
    output logic [LANES*DATA_WIDTH-1:0]     pe_k,
    output logic [LANES*DATA_WIDTH-1:0]     pe_in,
    output logic                            pe_first,
    input  logic [LANES*OUT_DATA_WIDTH-1:0] pe_sum,
    output logic                            res_valid,
    input  logic                            res_ready,
    output logic [LANES*OUT_DATA_WIDTH-1:0] res_data
);

    localparam int TAP_W = $clog2(TAPS);
    localparam int VEC_W = LANES * DATA_WIDTH;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_STREAM  = 3'd1;
    localparam logic [2:0] S_DRAIN   = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_OUTPUT  = 3'd4;

    localparam logic [TAP_W:0]   TAP_LIMIT = (TAP_W + 1)'(TAPS);
    localparam logic [TAP_W-1:0] TAP_LAST  = TAP_W'(TAPS - 1);

    logic [2:0]       state_reg, state_next;
    logic [TAP_W-1:0] tap_cnt_reg;
    logic [15:0]      pix_cnt_reg;
    logic [15:0]      num_reg;
    logic             done_reg;
    logic             res_valid_reg;
    logic [VEC_W-1:0] pe_k_reg, pe_in_reg;
    logic             pe_first_reg;
    logic [LANES*OUT_DATA_WIDTH-1:0] res_data_reg;

    logic [VEC_W-1:0] weight_mem [TAPS];

    logic tap_hs, res_hs, last_tap, last_pix, wr_ok;

    assign busy      = (state_reg != S_IDLE);
    assign act_ready = (state_reg == S_STREAM);
    assign done      = done_reg;
    assign res_valid = res_valid_reg;
    assign res_data  = res_data_reg;
    assign pe_k      = pe_k_reg;
    assign pe_in     = pe_in_reg;
    assign pe_first  = pe_first_reg;

    assign tap_hs   = act_ready && act_valid;
    assign res_hs   = (state_reg == S_OUTPUT) && res_valid_reg && res_ready;
    assign last_tap = (tap_cnt_reg == TAP_LAST);
    assign last_pix = ((pix_cnt_reg + 16'd1) == num_reg);
    // Out-of-range addresses are compared one bit wider so TAPS = 2^n still works.
    assign wr_ok    = w_wr_en && (state_reg == S_IDLE) && ({1'b0, w_wr_addr} < TAP_LIMIT);

    generate
        for (genvar gi = 0; gi < TAPS; gi++) begin : g_wmem
            always_ff @(posedge clk) begin
                if (reset) begin
                    weight_mem[gi] <= '0;
                end else if (wr_ok && (w_wr_addr == TAP_W'(gi))) begin
                    weight_mem[gi] <= w_wr_data;
                end
            end
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:    if (start && (num_pixels != 16'd0)) state_next = S_STREAM;
            S_STREAM:  if (tap_hs && last_tap) state_next = S_DRAIN;
            S_DRAIN:   state_next = S_CAPTURE;
            S_CAPTURE: state_next = S_OUTPUT;
            S_OUTPUT:  if (res_hs) state_next = last_pix ? S_IDLE : S_STREAM;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            tap_cnt_reg   <= '0;
            pix_cnt_reg   <= '0;
            num_reg       <= '0;
            done_reg      <= 1'b0;
            res_valid_reg <= 1'b0;
            res_data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            done_reg  <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        if (num_pixels == 16'd0) begin
                            done_reg <= 1'b1;
                        end else begin
                            num_reg     <= num_pixels;
                            pix_cnt_reg <= '0;
                            tap_cnt_reg <= '0;
                        end
                    end
                end
                S_STREAM: begin
                    if (tap_hs) begin
                        tap_cnt_reg <= last_tap ? '0 : tap_cnt_reg + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    res_data_reg  <= pe_sum;
                    res_valid_reg <= 1'b1;
                end
                S_OUTPUT: begin
                    if (res_hs) begin
                        res_valid_reg <= 1'b0;
                        pix_cnt_reg   <= pix_cnt_reg + 16'd1;
                        done_reg      <= last_pix;
                    end
                end
                default: ;
            endcase
        end
    end

    // Zero taps between accepts keep the free-running PE accumulators unchanged.
    always_ff @(posedge clk) begin
        if (reset || !tap_hs) begin
            pe_k_reg     <= '0;
            pe_in_reg    <= '0;
            pe_first_reg <= 1'b0;
        end else begin
            pe_k_reg     <= weight_mem[tap_cnt_reg];
            pe_in_reg    <= act_data;
            pe_first_reg <= (tap_cnt_reg == '0);
        end
    end

endmodule

// File: tb/tb_dw_tap_sequencer.sv
// Directed bench for dw_tap_sequencer with a behavioural accumulating PE row.
module tb_dw_tap_sequencer;

    localparam int DW    = 8;
    localparam int ODW   = 32;
    localparam int LANES = 4;
    localparam int TAPS  = 9;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   w_wr_en;
    logic [3:0]             w_wr_addr;
    logic [LANES*DW-1:0]    w_wr_data;
    logic                   start;
    logic [15:0]            num_pixels;
    logic                   busy, done;
    logic                   act_valid, act_ready;
    logic [LANES*DW-1:0]    act_data;
    logic [LANES*DW-1:0]    pe_k, pe_in;
    logic                   pe_first;
    logic [LANES*ODW-1:0]   pe_sum;
    logic                   res_valid, res_ready;
    logic [LANES*ODW-1:0]   res_data;

    int n_checks = 0;
    int n_err    = 0;

    logic [LANES*DW-1:0] act_tab [TAPS];
    logic signed [ODW-1:0] acc [LANES];

    always #5 clk = ~clk;

    dw_tap_sequencer #(
        .DATA_WIDTH(DW), .OUT_DATA_WIDTH(ODW), .LANES(LANES), .TAPS(TAPS)
    ) dut (
        .clk(clk), .reset(reset),
        .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data),
        .start(start), .num_pixels(num_pixels), .busy(busy), .done(done),
        .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
        .pe_k(pe_k), .pe_in(pe_in), .pe_first(pe_first), .pe_sum(pe_sum),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
    );

    function automatic logic signed [ODW-1:0] mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic signed [ODW-1:0] x, y;
        x = ODW'($signed(a));
        y = ODW'($signed(b));
        return x * y;
    endfunction

    // PE row: product registered every cycle, first_data restarts the sum.
    always @(posedge clk) begin
        for (int l = 0; l < LANES; l++) begin
            if (reset) acc[l] <= '0;
            else if (pe_first) acc[l] <= mul(pe_k[l*DW +: DW], pe_in[l*DW +: DW]);
            else acc[l] <= acc[l] + mul(pe_k[l*DW +: DW], pe_in[l*DW +: DW]);
        end
    end

    always_comb begin
        pe_sum = '0;
        for (int l = 0; l < LANES; l++) pe_sum[l*ODW +: ODW] = acc[l];
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write_w(input logic [3:0] addr, input logic [LANES*DW-1:0] data);
        w_wr_en = 1'b1; w_wr_addr = addr; w_wr_data = data;
        tick;
        w_wr_en = 1'b0;
    endtask

    task automatic load_uniform(input logic [LANES*DW-1:0] data);
        for (int t = 0; t < TAPS; t++) write_w(4'(t), data);
    endtask

    task automatic set_acts_ramp;
        for (int t = 0; t < TAPS; t++) act_tab[t] = {LANES{8'(t + 1)}};
    endtask

    task automatic set_acts_const(input logic [DW-1:0] v);
        for (int t = 0; t < TAPS; t++) act_tab[t] = {LANES{v}};
    endtask

    task automatic start_job(input logic [15:0] n);
        start = 1'b1; num_pixels = n;
        tick;
        start = 1'b0;
    endtask

    // Streams ntaps taps; in bubble mode act_valid toggles and bubble cycles are checked.
    task automatic stream(input bit bubble, input int ntaps, input string tag);
        int accepted = 0;
        int cyc = 0;
        bit hs;
        while (accepted < ntaps && cyc < 100) begin
            act_valid = bubble ? (cyc % 2 == 0) : 1'b1;
            act_data  = act_tab[accepted];
            hs = act_valid && act_ready;
            tick;
            if (hs) begin
                check({tag, "_first"}, 128'(pe_first), 128'(accepted == 0));
                accepted++;
            end else if (bubble) begin
                check({tag, "_bubble"}, {pe_k, pe_in, 31'd0, pe_first}, 128'd0);
            end
            cyc++;
        end
        act_valid = 1'b0;
        if (accepted < ntaps) check({tag, "_stream_timeout"}, 128'(accepted), 128'(ntaps));
    endtask

    task automatic wait_result(input string tag);
        tick;
        check({tag, "_lat1"}, 128'(res_valid), 128'd0);
        tick;
        check({tag, "_lat2"}, 128'(res_valid), 128'd1);
    endtask

    task automatic collect(input logic [LANES*ODW-1:0] exp, input int stall, input bit last, input string tag);
        for (int s = 0; s < stall; s++) begin
            res_ready = 1'b0;
            check({tag, "_stall_ready"}, {res_valid, act_ready}, 128'b10);
            check({tag, "_stall_data"}, res_data, exp);
            tick;
        end
        res_ready = 1'b1;
        check({tag, "_data"}, res_data, exp);
        tick;
        res_ready = 1'b0;
        check({tag, "_post"}, {res_valid, done, busy}, {1'b0, last, !last});
        if (last) begin
            tick;
            check({tag, "_done_once"}, 128'(done), 128'd0);
        end
    endtask

    task automatic one_window(input bit bubble, input logic [LANES*ODW-1:0] exp, input string tag);
        start_job(16'd1);
        check({tag, "_busy"}, 128'(busy), 128'd1);
        stream(bubble, TAPS, tag);
        wait_result(tag);
        collect(exp, 0, 1'b1, tag);
    endtask

    localparam logic [LANES*ODW-1:0] EXP45 = {LANES{32'd45}};

    initial begin
        reset = 1'b1; w_wr_en = 1'b0; w_wr_addr = '0; w_wr_data = '0;
        start = 1'b0; num_pixels = '0; act_valid = 1'b0; act_data = '0; res_ready = 1'b0;
        tick; tick;
        reset = 1'b0;
        check("reset_ctrl", {busy, done, act_ready, res_valid}, 128'd0);
        check("reset_pe", {pe_k, pe_in, 31'd0, pe_first}, 128'd0);
        check("reset_res", res_data, 128'd0);

        load_uniform({LANES{8'h01}});
        set_acts_ramp;
        one_window(1'b0, EXP45, "basic");

        load_uniform({LANES{8'h80}});
        set_acts_const(8'h80);
        one_window(1'b0, {LANES{32'd147456}}, "neg_extreme");

        load_uniform({8'd4, 8'd3, 8'd2, 8'd1});
        set_acts_const(8'h01);
        one_window(1'b0, {32'd36, 32'd27, 32'd18, 32'd9}, "lane_weights");

        load_uniform({LANES{8'h01}});
        set_acts_ramp;
        one_window(1'b1, EXP45, "bubbles");

        start_job(16'd3);
        for (int p = 0; p < 3; p++) begin
            stream(1'b0, TAPS, "bp");
            wait_result("bp");
            collect(EXP45, 5, p == 2, "bp");
        end

        start_job(16'd1);
        stream(1'b0, 4, "midrst");
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("midrst_state", {busy, res_valid, act_ready}, 128'd0);
        one_window(1'b0, 128'd0, "cleared_w");
        load_uniform({LANES{8'h01}});
        one_window(1'b0, EXP45, "after_rst");

        start_job(16'd0);
        check("zero_pix_done", {done, busy}, 128'b10);
        tick;
        check("zero_pix_after", {done, busy}, 128'b00);

        start_job(16'd1);
        write_w(4'd0, {LANES{8'h05}});
        stream(1'b0, TAPS, "wr_in_stream");
        wait_result("wr_in_stream");
        collect(EXP45, 0, 1'b1, "wr_in_stream");
        one_window(1'b0, EXP45, "wr_ignored");

        write_w(4'd9, {LANES{8'h05}});
        one_window(1'b0, EXP45, "addr9");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
